// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Each frame is one start bit (0), then DATA_WIDTH data bits sent LSB first,
// then an optional even/odd parity bit, then STOP_BITS stop bits (1).
// Frames are offered with a valid/ready handshake. The baud divisor and the
// payload are captured when a frame is accepted. tx_done pulses for one
// cycle when a frame completes.
//
// Optional feature, selected by the macro UART_TX_BREAK_EN:
//   When defined, the block has a tx_break input and a BREAK state. In BREAK
//   the line is held low. When tx_break falls, the line is driven high for
//   STOP_BITS bit periods, and then the block returns to IDLE without a
//   tx_done pulse.
//   When undefined, there is no tx_break port and no BREAK state.

module uart_tx_param #(
    parameter int DATA_WIDTH  = 8,   // data bits per frame, 5..9
    parameter int PARITY_MODE = 0,   // 0 = none, 1 = even, 2 = odd
    parameter int STOP_BITS   = 1,   // 1 or 2
    parameter int DIV_WIDTH   = 16   // width of the baud divisor
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                  tx_break,
`endif
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality checks
    // ------------------------------------------------------------------
    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
            $error("uart_tx_param: DATA_WIDTH=%0d is outside 5..9", DATA_WIDTH);
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
            $error("uart_tx_param: PARITY_MODE=%0d is not 0, 1 or 2", PARITY_MODE);
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS=%0d is not 1 or 2", STOP_BITS);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);
    localparam logic [3:0]           LAST_DATA  = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]           LAST_STOP  = 4'(STOP_BITS - 1);
    localparam bit                   HAS_PARITY = (PARITY_MODE != 0);
    localparam bit                   ODD_PARITY = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        ,
        S_BREAK
`endif
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q;
    logic                    tx_q;
    logic                    ready_q;
    logic                    busy_q;
    logic                    done_q;
    logic [DATA_WIDTH-1:0]   shift_q;     // remaining data bits, LSB goes out next
    logic [DIV_WIDTH-1:0]    period_q;    // clocks per bit for the current frame
    logic [DIV_WIDTH-1:0]    div_cnt_q;   // 0 .. period_q-1 within a bit
    logic [3:0]              bit_cnt_q;   // data bit or stop bit index
    logic                    parity_q;    // parity bit captured on accept
`ifdef UART_TX_BREAK_EN
    logic                    brk_q;       // current STOP phase is the break recovery
`endif

    // Next-frame values that are captured on accept
    logic [DIV_WIDTH-1:0]    period_d;
    logic                    parity_d;
    // High in the last clock of the current bit period
    logic                    bit_end;

    // Capture values for the next frame, and detect the end of a bit period
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        period_d = baud_div;
        if (baud_div == '0) begin
            period_d = DIV_ONE;
        end
        parity_d = ^tx_data;
        if (ODD_PARITY) begin
            parity_d = ~parity_d;
        end
        bit_end = (div_cnt_q == (period_q - DIV_ONE));
    end

    // Frame FSM: sequencing, bit timing, and registered line and handshake outputs
    always_ff @(posedge clk) begin
        // NOTE: state is updated only with non-blocking assignments. Every
        // register then sees the values from before the edge, whatever the
        // order of the statements.
        if (reset) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            shift_q   <= '0;
            period_q  <= DIV_ONE;       // one clock per bit until a frame is latched
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q     <= 1'b0;
`endif
        end else begin
            // tx_done is a pulse. Only the STOP -> IDLE edge sets it.
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    tx_q      <= 1'b1;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
`ifdef UART_TX_BREAK_EN
                    // A break request wins over a pending frame
                    if (tx_break) begin
                        state_q <= S_BREAK;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else
`endif
                    if (tx_valid && ready_q) begin
                        state_q  <= S_START;
                        tx_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        shift_q  <= tx_data;
                        period_q <= period_d;
                        parity_q <= parity_d;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_ONE;
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        div_cnt_q <= '0;
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            if (HAS_PARITY) begin
                                state_q <= S_PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_ONE;
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= S_STOP;
                        tx_q      <= 1'b1;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_ONE;
                    end
                end

                S_STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end) begin
                        div_cnt_q <= '0;
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_IDLE;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
                            // Break recovery ends silently, without a completion pulse
                            done_q    <= ~brk_q;
                            brk_q     <= 1'b0;
`else
                            done_q    <= 1'b1;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_ONE;
                    end
                end

`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    tx_q      <= 1'b0;
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    // Release: reuse STOP to hold the line high for STOP_BITS periods
                    if (!tx_break) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        brk_q   <= 1'b1;
                    end
                end
`endif

                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------
    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed self-checking bench for uart_tx_param.
// Four instances cover 8N1 (group A), 8E1 and 8O1 (group B, which share
// their inputs) and 7N2 (group C). Inputs are driven on the falling edge,
// and outputs are sampled on the falling edge.
// When UART_TX_BREAK_EN is defined, the break sequence on group A also runs.

module tb_uart_tx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Group A: 8N1
    logic        rst_a, valid_a, brk_a;
    logic [7:0]  data_a;
    logic [15:0] baud_a;
    logic        tx_a, ready_a, busy_a, done_a;
    // Group B: 8E1 and 8O1 (shared inputs)
    logic        rst_b, valid_b;
    logic [7:0]  data_b;
    logic [15:0] baud_b;
    logic        tx_e, ready_e, busy_e, done_e;
    logic        tx_o, ready_o, busy_o, done_o;
    // Group C: 7N2
    logic        rst_c, valid_c;
    logic [6:0]  data_c;
    logic [15:0] baud_c;
    logic        tx_c, ready_c, busy_c, done_c;
    logic        brk_off;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_param #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1), .DIV_WIDTH(16)) u_a (
        .clk(clk), .reset(rst_a), .baud_div(baud_a), .tx_data(data_a), .tx_valid(valid_a),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk_a),
`endif
        .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a), .tx(tx_a));

    uart_tx_param #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1), .DIV_WIDTH(16)) u_e (
        .clk(clk), .reset(rst_b), .baud_div(baud_b), .tx_data(data_b), .tx_valid(valid_b),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk_off),
`endif
        .tx_ready(ready_e), .tx_busy(busy_e), .tx_done(done_e), .tx(tx_e));

    uart_tx_param #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1), .DIV_WIDTH(16)) u_o (
        .clk(clk), .reset(rst_b), .baud_div(baud_b), .tx_data(data_b), .tx_valid(valid_b),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk_off),
`endif
        .tx_ready(ready_o), .tx_busy(busy_o), .tx_done(done_o), .tx(tx_o));

    uart_tx_param #(.DATA_WIDTH(7), .PARITY_MODE(0), .STOP_BITS(2), .DIV_WIDTH(16)) u_c (
        .clk(clk), .reset(rst_c), .baud_div(baud_c), .tx_data(data_c), .tx_valid(valid_c),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk_off),
`endif
        .tx_ready(ready_c), .tx_busy(busy_c), .tx_done(done_c), .tx(tx_c));

    // {tx, ready, busy, done} of instance sel: 0=A, 1=E, 2=O, 3=C
    function automatic logic [3:0] obs(input int sel);
        case (sel)
            0:       obs = {tx_a, ready_a, busy_a, done_a};
            1:       obs = {tx_e, ready_e, busy_e, done_e};
            2:       obs = {tx_o, ready_o, busy_o, done_o};
            default: obs = {tx_c, ready_c, busy_c, done_c};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at the falling edge of cycle 1 of a frame. Bit b of the frame
    // (bit 0 is the start bit) lasts for 'period' cycles. At cycle mid_cyc the
    // group's data, baud and break inputs are overwritten. Returns at the
    // falling edge of the completion cycle.
    task automatic frame_chk(input string tag, input int sel, input logic [15:0] bits,
                             input int nbits, input int period, input int mid_cyc,
                             input logic [7:0] mid_data, input logic [15:0] mid_baud,
                             input logic mid_brk);
        logic [3:0] o;
        int cyc;
        cyc = 1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < period; c++) begin
                o = obs(sel);
                check($sformatf("%s.c%0d.tx", tag, cyc), 32'(o[3]), 32'(bits[b]));
                check($sformatf("%s.c%0d.rdy_busy_done", tag, cyc), 32'(o[2:0]), 32'b010);
                if (cyc == mid_cyc) begin
                    case (sel)
                        0:       begin data_a = mid_data; baud_a = mid_baud; brk_a = mid_brk; end
                        1, 2:    begin data_b = mid_data; baud_b = mid_baud; end
                        default: begin data_c = mid_data[6:0]; baud_c = mid_baud; end
                    endcase
                end
                cyc++;
                @(negedge clk);
            end
        end
        check($sformatf("%s.done_cycle", tag), 32'(obs(sel)), 32'b1101);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        brk_a = 1'b0; brk_off = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        baud_a = '0; baud_b = '0; baud_c = '0;
        repeat (3) @(negedge clk);

        // Reset state: tx=1, ready=0, busy=0, done=0
        for (int s = 0; s < 4; s++) check($sformatf("reset.u%0d", s), 32'(obs(s)), 32'b1000);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) check($sformatf("ready_after_reset.u%0d", s), 32'(obs(s)), 32'b1100);

        // 1: 8N1, baud 4, 0xA5. Start in cycles 1-4, stop in 37-40, done in 41
        data_a = 8'hA5; baud_a = 16'd4; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        frame_chk("t1", 0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, -1, 8'h00, 16'd0, 1'b0);
        @(negedge clk);
        check("t1.idle", 32'(obs(0)), 32'b1100);

        // 2: baud 2, 0x07 has three ones, so even parity = 1; 11 bits x 2 = 22 clocks
        data_b = 8'h07; baud_b = 16'd2; valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        frame_chk("t2e", 1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 2, -1, 8'h00, 16'd0, 1'b0);
        @(negedge clk);
        check("t2e.idle", 32'(obs(1)), 32'b1100);
        // odd parity on the same byte = 0
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        frame_chk("t2o", 2, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 2, -1, 8'h00, 16'd0, 1'b0);
        @(negedge clk);
        check("t2o.idle", 32'(obs(2)), 32'b1100);

        // 3: 7N2, baud 0 gives a period of 1. 0x35 -> 10 clocks, last 2 high
        data_c = 7'h35; baud_c = 16'd0; valid_c = 1'b1;
        @(negedge clk);
        valid_c = 1'b0;
        frame_chk("t3", 3, {6'b0, 2'b11, 7'h35, 1'b0}, 10, 1, -1, 8'h00, 16'd0, 1'b0);
        @(negedge clk);
        check("t3.no_done", 32'(obs(3)), 32'b1100);

        // 4: valid held high, 0x55 then 0xAA at baud 3. Inputs are overwritten mid-frame
        data_a = 8'h55; baud_a = 16'd3; valid_a = 1'b1;
        @(negedge clk);
        frame_chk("t4a", 0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 3, 5, 8'hFF, 16'd7, 1'b0);
        data_a = 8'hAA; baud_a = 16'd3;       // accepted in the done cycle
        @(negedge clk);
        frame_chk("t4b", 0, {6'b0, 1'b1, 8'hAA, 1'b0}, 10, 3, 8, 8'h00, 16'd1, 1'b0);
        valid_a = 1'b0;
        @(negedge clk);
        check("t4.idle", 32'(obs(0)), 32'b1100);

        // 5: reset in the middle of 0x3C. Cycle 10 is data bit 1 (0)
        data_a = 8'h3C; baud_a = 16'd4; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (9) @(negedge clk);
        check("t5.mid_data", 32'(obs(0)), 32'b0010);
        rst_a = 1'b1;
        @(negedge clk);
        check("t5.in_reset", 32'(obs(0)), 32'b1000);
        rst_a = 1'b0;
        @(negedge clk);
        check("t5.ready_back", 32'(obs(0)), 32'b1100);
        @(negedge clk);
        check("t5.no_done", 32'(obs(0)), 32'b1100);
        data_a = 8'h81; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        frame_chk("t5f", 0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, 4, -1, 8'h00, 16'd0, 1'b0);
        @(negedge clk);
        check("t5.idle", 32'(obs(0)), 32'b1100);

`ifdef UART_TX_BREAK_EN
        // 6: break raised mid-frame. The frame finishes first, then the line
        // is held low. Break wins over valid in the done cycle.
        data_a = 8'h0F; baud_a = 16'd4; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        frame_chk("t6f", 0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 4, 12, 8'h0F, 16'd4, 1'b1);
        valid_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            check($sformatf("t6.break.c%0d", i), 32'(obs(0)), 32'b0010);
            valid_a = 1'b0;
            if (i == 49) brk_a = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6.recover.c%0d", i), 32'(obs(0)), 32'b1010);
            @(negedge clk);
        end
        check("t6.idle", 32'(obs(0)), 32'b1100);
        @(negedge clk);
        check("t6.still_idle", 32'(obs(0)), 32'b1100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
